// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/single-step sequencer producing a one-clk advance strobe for the core.
// Optional breakpoint support (ports bp_addr_i/bp_valid_i, BREAK state) is built when CPU_RUN_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned BASE_SHIFT      = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PC_W            = 32,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run_i,
    input  logic             step_i,
    input  logic [2:0]       rate_sel_i,
    input  logic             clear_i,
    input  logic [PC_W-1:0]  pc_i,
`ifdef CPU_RUN_BREAKPOINT_EN
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic             bp_valid_i,
`endif
    output logic             cpu_en_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_e;

    localparam int unsigned PS_W = BASE_SHIFT + 8;
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic             run_meta_q, run_s_q;
    logic             step_meta_q, step_s_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             step_db_q, step_db_d;
    logic             step_db_dly_q;
    logic             step_req;

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [PS_W-1:0]  presc_lim;
    int unsigned      shamt;
    logic             tick;

    state_e           state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef CPU_RUN_BREAKPOINT_EN
    logic             bp_hit;
    assign bp_hit = bp_valid_i && (pc_i == bp_addr_i);
`else
    logic             pc_unused;
    assign pc_unused = ^pc_i;
`endif

    // Input synchronisers and step debounce state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_meta_q    <= 1'b0;
            run_s_q       <= 1'b0;
            step_meta_q   <= 1'b0;
            step_s_q      <= 1'b0;
            db_cnt_q      <= '0;
            step_db_q     <= 1'b0;
            step_db_dly_q <= 1'b0;
        end else begin
            run_meta_q    <= run_i;
            run_s_q       <= run_meta_q;
            step_meta_q   <= step_i;
            step_s_q      <= step_meta_q;
            db_cnt_q      <= db_cnt_d;
            step_db_q     <= step_db_d;
            step_db_dly_q <= step_db_q;
        end
    end

    // Count only while the synchronised level disagrees with the accepted level;
    // any return to agreement restarts the count from zero.
    always_comb begin
        db_cnt_d  = '0;
        step_db_d = step_db_q;
        if (step_s_q != step_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                step_db_d = step_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign step_req = step_db_q & ~step_db_dly_q;

    // Prescaler: >= compare so a lowered rate_sel_i mid-period ticks on the next cycle.
    always_comb begin
        shamt     = BASE_SHIFT + 32'(rate_sel_i);
        presc_lim = (PS_W'(1) << shamt) - PS_W'(1);
        tick      = (state_q == ST_RUN) && (presc_q >= presc_lim);
        if ((state_q != ST_RUN) || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Sequencer: the strobe is decided here and registered into cpu_en_q.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (run_s_q) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_s_q) begin
                    state_d = ST_HALT;
`ifdef CPU_RUN_BREAKPOINT_EN
                end else if (tick && bp_hit) begin
                    state_d = ST_BREAK;
`endif
                end else if (tick) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
`ifdef CPU_RUN_BREAKPOINT_EN
            ST_BREAK: begin
                if (step_req) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end else if (!run_s_q) begin
                    state_d = ST_HALT;
                end
            end
`endif
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_HALT;
            cpu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
        end
    end

    // Retired-instruction counter; clear wins over a coincident strobe.
    always_comb begin
        if (clear_i) begin
            cnt_d = '0;
        end else if (cpu_en_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cpu_en_o    = cpu_en_q;
    assign state_o     = state_q;
    assign cycle_cnt_o = cnt_q;

    a_step_strobes: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ST_STEP) |-> cpu_en_q);

`ifndef CPU_RUN_BREAKPOINT_EN
    a_no_break: assert property (@(posedge clk) disable iff (!rstn)
        state_q != ST_BREAK);
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with small timing parameters and a PC+=1 core model.
// Breakpoint scenario is exercised only when CPU_RUN_BREAKPOINT_EN is defined.
module tb_cpu_run_ctrl;

    localparam int unsigned BS   = 2;
    localparam int unsigned DBC  = 4;
    localparam int unsigned PCW  = 8;
    localparam int unsigned CW   = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           run_i = 1'b0;
    logic           step_i = 1'b0;
    logic [2:0]     rate_sel_i = 3'd0;
    logic           clear_i = 1'b0;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] bp_addr = '0;
    logic           bp_valid = 1'b0;
    logic           cpu_en_o;
    logic [1:0]     state_o;
    logic [CW-1:0]  cycle_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .BASE_SHIFT      (BS),
        .DEBOUNCE_CYCLES (DBC),
        .PC_W            (PCW),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .run_i       (run_i),
        .step_i      (step_i),
        .rate_sel_i  (rate_sel_i),
        .clear_i     (clear_i),
        .pc_i        (pc),
`ifdef CPU_RUN_BREAKPOINT_EN
        .bp_addr_i   (bp_addr),
        .bp_valid_i  (bp_valid),
`endif
        .cpu_en_o    (cpu_en_o),
        .state_o     (state_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    // Core model: PC advances by one per strobe.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) pc <= '0;
        else if (cpu_en_o) pc <= pc + 8'd1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run_i = 0; step_i = 0; clear_i = 0; rate_sel_i = 0; bp_valid = 0; bp_addr = '0;
        rstn = 0;
        repeat (3) cyc();
        rstn = 1;
        cyc();
    endtask

    task automatic wait_pulse(input int maxc, output int n, output bit got);
        n = 0; got = 0;
        while (n < maxc && !got) begin
            cyc();
            n++;
            if (cpu_en_o === 1'b1) got = 1;
        end
    endtask

    task automatic test_reset();
        rstn = 1; run_i = 1; rate_sel_i = 0;
        repeat (12) cyc();
        #2 rstn = 0;
        #1;
        n_checks++; if (cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0d expected 0", cpu_en_o); end
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        n_checks++; if (cycle_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt_o); end
        run_i = 0;
        repeat (2) cyc();
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_hold_state: got %0d expected 0", state_o); end
        rstn = 1;
        cyc();
    endtask

    task automatic test_run();
        int r, per, n;
        bit got;
        do_reset();
        r = int'($urandom_range(0, 2));
        per = 1 << (BS + r);
        rate_sel_i = 3'(r);
        run_i = 1;
        n = 0;
        while (state_o !== 2'd1 && n < 10) begin cyc(); n++; end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL run_entry_latency: got %0d expected 3", n); end
        for (int k = 1; k <= 3; k++) begin
            wait_pulse(per + 4, n, got);
            n_checks++;
            if (!got || n != ((k == 1) ? per : per - 1)) begin
                n_fail++; $display("FAIL run_gap%0d: got %0d (seen=%0d) expected %0d", k, n, got, (k == 1) ? per : per - 1);
            end
            cyc();
            n_checks++; if (cycle_cnt_o !== 4'(k)) begin n_fail++; $display("FAIL run_cnt%0d: got %0d expected %0d", k, cycle_cnt_o, k); end
            n_checks++; if (pc !== 8'(k)) begin n_fail++; $display("FAIL run_pc%0d: got %0d expected %0d", k, pc, k); end
        end
        run_i = 0;
        repeat (4) cyc();
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL run_stop_state: got %0d expected 0", state_o); end
    endtask

    // One press: optional random bounce of 1..3 cycles at each edge around a clean hold.
    task automatic press(input int hold, input bit bounce, input int exp_pulses, input string nm);
        bit seq[$];
        int pulses, start_pc, after;
        bit prev;
        seq.delete();
        if (bounce) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) seq.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < hold; i++) seq.push_back(1'b1);
        if (bounce) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) seq.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 14; i++) seq.push_back(1'b0);
        pulses = 0; prev = 0; after = 0; start_pc = int'(pc);
        foreach (seq[i]) begin
            step_i = seq[i];
            cyc();
            if (prev) begin
                n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL %s_post_state: got %0d expected 0", nm, state_o); end
            end
            prev = 0;
            if (cpu_en_o === 1'b1) begin
                pulses++; prev = 1;
                n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL %s_pulse_state: got %0d expected 2", nm, state_o); end
            end
        end
        after = int'(pc) - start_pc;
        n_checks++; if (pulses != exp_pulses) begin n_fail++; $display("FAIL %s_pulses: got %0d expected %0d", nm, pulses, exp_pulses); end
        n_checks++; if (after != exp_pulses) begin n_fail++; $display("FAIL %s_pc_delta: got %0d expected %0d", nm, after, exp_pulses); end
    endtask

    task automatic test_step();
        do_reset();
        press(12, 1'b1, 1, "step_bouncy12");
        press(DBC - 1, 1'b0, 0, "step_glitch3");
        press(DBC, 1'b0, 1, "step_exact4");
        press(int'($urandom_range(5, 12)), 1'b1, 1, "step_rand");
        n_checks++; if (cycle_cnt_o !== 4'd3) begin n_fail++; $display("FAIL step_cnt: got %0d expected 3", cycle_cnt_o); end
    endtask

    // Drop run so run_s falls in the tick cycle (d=0) or one cycle later (d=1).
    task automatic test_run_drop();
        int r, per, n, pulses;
        bit got;
        for (int d = 0; d <= 1; d++) begin
            do_reset();
            r = int'($urandom_range(0, 1));
            per = 1 << (BS + r);
            rate_sel_i = 3'(r);
            run_i = 1;
            wait_pulse(per + 8, n, got);
            n_checks++; if (!got) begin n_fail++; $display("FAIL drop%0d_first: got no pulse expected pulse", d); end
            repeat (per - 3 + d) cyc();
            run_i = 0;
            pulses = 0;
            for (int i = 0; i < 10; i++) begin
                cyc();
                if (cpu_en_o === 1'b1) pulses++;
            end
            n_checks++; if (pulses != d) begin n_fail++; $display("FAIL drop%0d_pulses: got %0d expected %0d", d, pulses, d); end
            n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL drop%0d_state: got %0d expected 0", d, state_o); end
            n_checks++; if (cycle_cnt_o !== 4'(1 + d)) begin n_fail++; $display("FAIL drop%0d_cnt: got %0d expected %0d", d, cycle_cnt_o, 1 + d); end
        end
    endtask

    task automatic test_wrap_clear();
        int n, since_clr;
        bit got;
        do_reset();
        rate_sel_i = 0;
        run_i = 1;
        since_clr = 0;
        for (int k = 1; k <= 17; k++) begin
            wait_pulse(16, n, got);
            if (got) since_clr++;
            cyc();
            n_checks++; if (cycle_cnt_o !== 4'(since_clr % 16)) begin n_fail++; $display("FAIL wrap_cnt%0d: got %0d expected %0d", k, cycle_cnt_o, since_clr % 16); end
        end
        wait_pulse(16, n, got);
        clear_i = 1;
        cyc();
        clear_i = 0;
        since_clr = 0;
        n_checks++; if (!got || cycle_cnt_o !== 4'd0) begin n_fail++; $display("FAIL clear_vs_pulse: got %0d (seen=%0d) expected 0", cycle_cnt_o, got); end
        wait_pulse(16, n, got);
        if (got) since_clr++;
        cyc();
        n_checks++; if (cycle_cnt_o !== 4'(since_clr)) begin n_fail++; $display("FAIL clear_resume: got %0d expected %0d", cycle_cnt_o, since_clr); end
        clear_i = 1;
        cyc();
        clear_i = 0;
        n_checks++; if (cycle_cnt_o !== 4'd0) begin n_fail++; $display("FAIL clear_idle: got %0d expected 0", cycle_cnt_o); end
        run_i = 0;
        repeat (4) cyc();
    endtask

    task automatic test_async_reset();
        int n, per;
        bit got;
        do_reset();
        rate_sel_i = 3'd1;
        per = 8;
        run_i = 1;
        wait_pulse(per + 8, n, got);
        wait_pulse(per + 2, n, got);
        n_checks++; if (!got || cycle_cnt_o !== 4'd1) begin n_fail++; $display("FAIL areset_pre: got cnt %0d (seen=%0d) expected 1", cycle_cnt_o, got); end
        #2 rstn = 0;
        #1;
        n_checks++; if (cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL areset_en: got %0d expected 0", cpu_en_o); end
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL areset_state: got %0d expected 0", state_o); end
        n_checks++; if (cycle_cnt_o !== 4'd0) begin n_fail++; $display("FAIL areset_cnt: got %0d expected 0", cycle_cnt_o); end
        repeat (2) cyc();
        rstn = 1;
        n = 0;
        while (state_o !== 2'd1 && n < 10) begin cyc(); n++; end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL areset_rerun_latency: got %0d expected 3", n); end
        wait_pulse(per + 4, n, got);
        n_checks++; if (!got || n != per) begin n_fail++; $display("FAIL areset_first_gap: got %0d (seen=%0d) expected %0d", n, got, per); end
        run_i = 0;
        repeat (4) cyc();
    endtask

`ifdef CPU_RUN_BREAKPOINT_EN
    task automatic test_breakpoint();
        int n, pulses;
        bit prev;
        do_reset();
        bp_addr = 8'd3;
        bp_valid = 1;
        rate_sel_i = 0;
        run_i = 1;
        n = 0; pulses = 0;
        while (state_o !== 2'd3 && n < 40) begin
            cyc(); n++;
            if (cpu_en_o === 1'b1) pulses++;
        end
        n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL bp_state: got %0d expected 3", state_o); end
        n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL bp_pulses: got %0d expected 3", pulses); end
        n_checks++; if (pc !== 8'd3) begin n_fail++; $display("FAIL bp_pc: got %0d expected 3", pc); end
        n_checks++; if (cycle_cnt_o !== 4'd3) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 3", cycle_cnt_o); end
        pulses = 0;
        repeat (10) begin cyc(); if (cpu_en_o === 1'b1) pulses++; end
        n_checks++; if (state_o !== 2'd3 || pulses != 0) begin n_fail++; $display("FAIL bp_hold: got state %0d pulses %0d expected 3 and 0", state_o, pulses); end
        // Step request and run release arrive together; step must win.
        step_i = 1;
        pulses = 0; prev = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 4) run_i = 0;
            if (i == 12) step_i = 0;
            cyc();
            if (prev) begin
                n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL bp_step_post: got %0d expected 0", state_o); end
            end
            prev = 0;
            if (cpu_en_o === 1'b1) begin
                pulses++; prev = 1;
                n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL bp_step_state: got %0d expected 2", state_o); end
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bp_step_pulses: got %0d expected 1", pulses); end
        n_checks++; if (pc !== 8'd4) begin n_fail++; $display("FAIL bp_step_pc: got %0d expected 4", pc); end
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL bp_final_state: got %0d expected 0", state_o); end
        bp_valid = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_step();
        test_run_drop();
        test_wrap_clear();
        test_async_reset();
`ifdef CPU_RUN_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
